instr_issue_queue: RTL and testbench
====================================

// Module: instr_issue_queue
// PURPOSE
//  Decode and issue-buffer stage directly upstream of the scoreboard. Accepts packed instruction
//  words from fetch over a valid/ready handshake, decodes the op into an FU type, and buffers up to
//  DEPTH entries in program order. Presents the head entry on the scoreboard's inst_* interface
//  and holds it stable while stall is high. Drops illegal ops and flags them.
// PARAMETERS
//  DEPTH     4   queue entries (power of 2, >=2)
//  REG_BITS  5   register specifier width
//  CNT_BITS  3   occupancy width, = log2(DEPTH)+1
// PORTS
//  clk           in   1          clock, rising edge
//  rst           in   1          synchronous reset, active-high
//  flush         in   1          synchronous queue clear
//  in_valid      in   1          fetch word valid
//  in_ready      out  1          queue can accept (count < DEPTH)
//  in_instr      in   3+3*RB     [op(3) | fi | fj | fk], MSB first; RB = REG_BITS
//  inst_valid    out  1          head entry valid, to scoreboard
//  inst_op       out  3          head op
//  inst_fi       out  REG_BITS   head dest reg
//  inst_fj       out  REG_BITS   head src j
//  inst_fk       out  REG_BITS   head src k
//  inst_fu_type  out  2          decoded FU type
//  stall         in   1          scoreboard cannot issue head this cycle
//  count         out  CNT_BITS   current occupancy
//  illegal_seen  out  1          sticky: an op==7 word was accepted and dropped
// BEHAVIOUR
//  - Reset and flush: all outputs are 0, pointers and count are 0, and in_ready=1 after reset.
//    Reset also clears illegal_seen. Flush does not clear illegal_seen.
//  - Push: the queue pushes when in_valid && in_ready && op!=7. in_ready = (count<DEPTH) && !flush.
//    When full, in_ready=0 even if a pop happens in the same cycle (no same-cycle credit).
//  - Illegal op: op==7 with in_valid && in_ready is consumed. It is not enqueued and sets
//    illegal_seen the next cycle.
//  - Decode at push:
//      op 0..4 (ADD, SUB, AND, OR, XOR) -> fu_type 2'd0 (ALU)
//      op 5 (MUL) -> 2'd2
//      op 6 (DIV) -> 2'd3
//    The decoded fu_type is stored with the entry.
//  - Pop: the queue pops when inst_valid && !stall. While stall=1, every inst_* output is stable.
//  - Outputs are driven from the head storage. inst_valid = (count!=0).
//    inst_* fields are 0 when the queue is empty.
//  - Latency: fetch to inst_valid is 1 cycle. A word pushed at edge N is visible after edge N.
//  - Simultaneous push and pop with 0<count<DEPTH: count is unchanged, both pointers advance,
//    and order is preserved.
//  - Push while empty: the word becomes head. Pop has no effect while empty.
//  - Pointers wrap modulo DEPTH. count saturates at neither bound, because the legal handshake
//    prevents overflow and underflow.
//  - Flush has priority over push and pop in the same cycle. A word offered during a flush
//    cycle is not accepted.
//  - Reset asserted mid-stream discards every entry. There is no partial state.
// CONFIGURATION
//  IQ_BYPASS_EN defined:
//    - When count==0 and in_valid with a legal op, the inst_* outputs are driven
//      combinationally from in_instr and the decode.
//    - If stall==0 that same cycle, the word issues without being stored (0-cycle latency,
//      count stays 0).
//    - If stall==1, the word is stored normally.
//  IQ_BYPASS_EN undefined: outputs come only from storage; the minimum latency is 1 cycle.
// TESTING
//  1. Reset with rst=1 for 3 cycles -> inst_valid=0, count=0, in_ready=1, illegal_seen=0.
//  2. Push ADD r3=r1+r2 with stall=0 -> next cycle inst_valid=1, op=0, fi=3, fj=1, fk=2,
//     fu_type=0; popped that cycle, so count returns to 0.
//  3. Hold stall=1 and push MUL r10, DIV r12, ADD r11, SUB r7, then offer a 5th word ->
//     count=4, in_ready=0, 5th word not taken, head stays MUL fi=10 fu_type=2.
//     Release stall -> issue order 10, 12, 11, 7 with fu_types 2, 3, 0, 0.
//  4. Push op=7 -> count unchanged and illegal_seen=1 from the next cycle.
//     Then flush -> count=0, illegal_seen still 1.
//  5. With count=2 and stall=0, push every cycle for 6 cycles -> count stays 2 and the issue
//     order matches push order, covering pointer wrap.
//  6. IQ_BYPASS_EN only: empty queue, stall=0, push XOR r4 -> inst_valid=1 the same cycle,
//     count stays 0.

Source files
------------

// File: rtl/instr_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_issue_queue
// Description : Decode and issue buffer in front of the scoreboard. Accepts
//               packed instruction words from fetch over valid/ready. Each
//               word's op is decoded into an FU type, and up to DEPTH
//               entries are held in program order. The head entry is
//               presented on the inst_* interface and held stable while
//               stall is high. Illegal ops (op==7) are consumed, dropped
//               and recorded in a sticky flag.
// Options     : IQ_BYPASS_EN - when the queue is empty, a legal incoming
//               word is presented combinationally. If the scoreboard takes
//               it the same cycle, the word is never stored.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_issue_queue #(
  parameter int DEPTH    = 4,
  parameter int REG_BITS = 5,
  parameter int CNT_BITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3+3*REG_BITS-1:0] in_instr,
  output logic                  inst_valid,
  output logic [2:0]            inst_op,
  output logic [REG_BITS-1:0]   inst_fi,
  output logic [REG_BITS-1:0]   inst_fj,
  output logic [REG_BITS-1:0]   inst_fk,
  output logic [1:0]            inst_fu_type,
  input  logic                  stall,
  output logic [CNT_BITS-1:0]   count,
  output logic                  illegal_seen
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int IW       = 3 + 3*REG_BITS;
  // A stored entry is the instruction word with its decoded FU type appended.
  localparam int EW       = IW + 2;

  localparam logic [CNT_BITS-1:0] C_DEPTH      = CNT_BITS'(DEPTH);
  localparam logic [CNT_BITS-1:0] C_CNT_ZERO   = '0;
  localparam logic [2:0]          C_OP_MUL     = 3'd5;
  localparam logic [2:0]          C_OP_DIV     = 3'd6;
  localparam logic [2:0]          C_OP_ILLEGAL = 3'd7;
  localparam logic [1:0]          C_FU_ALU     = 2'd0;
  localparam logic [1:0]          C_FU_MUL     = 2'd2;
  localparam logic [1:0]          C_FU_DIV     = 2'd3;

  // Map an op to its functional unit. ADD..XOR share the ALU.
  function automatic logic [1:0] decode_fu(input logic [2:0] op);
    logic [1:0] fu;
    fu = C_FU_ALU;
    case (op)
      C_OP_MUL: fu = C_FU_MUL;
      C_OP_DIV: fu = C_FU_DIV;
      default:  fu = C_FU_ALU;
    endcase
    return fu;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [EW-1:0]       mem_q [DEPTH];
  logic [EW-1:0]       mem_d [DEPTH];
  logic [PTR_BITS-1:0] head_q, head_d;
  logic [PTR_BITS-1:0] tail_q, tail_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                illegal_q, illegal_d;

  // --------------------------------------------------------------------------
  // Incoming word fields and decode
  // --------------------------------------------------------------------------
  logic [2:0]          w_in_op;
  logic [REG_BITS-1:0] w_in_fi;
  logic [REG_BITS-1:0] w_in_fj;
  logic [REG_BITS-1:0] w_in_fk;
  logic [1:0]          w_in_fu;
  logic                w_in_legal;
  logic [EW-1:0]       w_in_entry;
  logic                w_accept;
  logic                w_push;
  logic                w_pop;
  logic                w_stored_valid;
  logic                w_byp_active;
  logic                w_byp_issue;
  logic [EW-1:0]       w_head_entry;

  assign w_in_op    = in_instr[IW-1 -: 3];
  assign w_in_fi    = in_instr[3*REG_BITS-1 -: REG_BITS];
  assign w_in_fj    = in_instr[2*REG_BITS-1 -: REG_BITS];
  assign w_in_fk    = in_instr[REG_BITS-1:0];
  assign w_in_fu    = decode_fu(w_in_op);
  assign w_in_legal = (w_in_op != C_OP_ILLEGAL);
  assign w_in_entry = {in_instr, w_in_fu};

  // No same-cycle credit: a pop while full does not open a slot for a push.
  assign in_ready = (count_q < C_DEPTH) && !flush;
  assign w_accept = in_valid && in_ready;

  assign w_stored_valid = (count_q != C_CNT_ZERO);

`ifdef IQ_BYPASS_EN
  // The incoming word may be issued directly only when nothing older is queued.
  assign w_byp_active = !w_stored_valid && w_accept && w_in_legal;
  assign w_byp_issue  = w_byp_active && !stall;
`else
  assign w_byp_active = 1'b0;
  assign w_byp_issue  = 1'b0;
`endif

  // A word that issued through the bypass is not also stored.
  assign w_push = w_accept && w_in_legal && !w_byp_issue;
  assign w_pop  = w_stored_valid && !stall;

  assign w_head_entry = mem_q[head_q];

  // --------------------------------------------------------------------------
  // Head presentation: stored head first, otherwise bypass word, otherwise 0.
  // --------------------------------------------------------------------------
  always_comb begin
    inst_valid   = 1'b0;
    inst_op      = '0;
    inst_fi      = '0;
    inst_fj      = '0;
    inst_fk      = '0;
    inst_fu_type = '0;
    if (w_stored_valid) begin
      inst_valid   = 1'b1;
      inst_op      = w_head_entry[EW-1 -: 3];
      inst_fi      = w_head_entry[3*REG_BITS+1 -: REG_BITS];
      inst_fj      = w_head_entry[2*REG_BITS+1 -: REG_BITS];
      inst_fk      = w_head_entry[REG_BITS+1 -: REG_BITS];
      inst_fu_type = w_head_entry[1:0];
    end else if (w_byp_active) begin
      inst_valid   = 1'b1;
      inst_op      = w_in_op;
      inst_fi      = w_in_fi;
      inst_fj      = w_in_fj;
      inst_fk      = w_in_fk;
      inst_fu_type = w_in_fu;
    end
  end

  assign count        = count_q;
  assign illegal_seen = illegal_q;

  // --------------------------------------------------------------------------
  // Next-state: flush clears pointers and occupancy ahead of any push or pop.
  // --------------------------------------------------------------------------
  always_comb begin
    mem_d     = mem_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    illegal_d = illegal_q || (w_accept && !w_in_legal);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (w_push) begin
        mem_d[tail_q] = w_in_entry;
        tail_d        = tail_q + 1'b1;
      end
      if (w_pop) begin
        head_d = head_q + 1'b1;
      end
      count_d = count_q + CNT_BITS'(w_push) - CNT_BITS'(w_pop);
    end
  end

  // Register update; reset discards every entry and the sticky illegal flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_issue_queue
// Description : Self-checking bench for instr_issue_queue. Stimulus queues
//               the expected issue stream; a monitor compares every issued
//               head against it. Direct checks cover occupancy, ready,
//               stability under stall and the sticky illegal flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_issue_queue;

  localparam int RB = 5;
  localparam int IW = 3 + 3*RB;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_instr;
  logic          inst_valid;
  logic [2:0]    inst_op;
  logic [RB-1:0] inst_fi;
  logic [RB-1:0] inst_fj;
  logic [RB-1:0] inst_fk;
  logic [1:0]    inst_fu_type;
  logic          stall;
  logic [2:0]    count;
  logic          illegal_seen;

  int checks = 0;
  int errors = 0;

  // {op, fi, fj, fk, fu}
  logic [IW+1:0] exp_q[$];

  instr_issue_queue #(.DEPTH(4), .REG_BITS(RB), .CNT_BITS(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .inst_valid   (inst_valid),
    .inst_op      (inst_op),
    .inst_fi      (inst_fi),
    .inst_fj      (inst_fj),
    .inst_fk      (inst_fk),
    .inst_fu_type (inst_fu_type),
    .stall        (stall),
    .count        (count),
    .illegal_seen (illegal_seen)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] fu_model(input logic [2:0] op);
    if (op == 3'd5) return 2'd2;
    if (op == 3'd6) return 2'd3;
    return 2'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [2:0] op, input logic [RB-1:0] fi,
                       input logic [RB-1:0] fj, input logic [RB-1:0] fk,
                       input logic expect_push);
    in_valid = 1'b1;
    in_instr = {op, fi, fj, fk};
    if (expect_push) exp_q.push_back({op, fi, fj, fk, fu_model(op)});
  endtask

  // Monitor: every head the scoreboard takes must match the next expected word.
  always @(negedge clk) begin
    if (!rst && inst_valid && !stall) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected actual=%0h required=none",
                 {inst_op, inst_fi, inst_fj, inst_fk, inst_fu_type});
      end else begin
        if ({inst_op, inst_fi, inst_fj, inst_fk, inst_fu_type} !== exp_q[0]) begin
          errors++;
          $display("FAIL issue_entry actual=%0h required=%0h",
                   {inst_op, inst_fi, inst_fj, inst_fk, inst_fu_type}, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  // Test 5 vectors: op, fi, fj, fk
  logic [2:0]    v_op [6] = '{3'd4, 3'd5, 3'd6, 3'd0, 3'd2, 3'd1};
  logic [RB-1:0] v_fi [6] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; stall = 1'b0;

    // 1. Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_illegal", 32'(illegal_seen), 32'd0);
    rst = 1'b0;
    tick();

    // 2. Single ADD r3 = r1 + r2
    offer(3'd0, 5'd3, 5'd1, 5'd2, 1'b1);
    #3;
`ifdef IQ_BYPASS_EN
    chk("add_same_cycle_valid", 32'(inst_valid), 32'd1);
`else
    chk("add_same_cycle_valid", 32'(inst_valid), 32'd0);
`endif
    tick();
    in_valid = 1'b0;
    #3;
`ifdef IQ_BYPASS_EN
    chk("add_count_next", 32'(count), 32'd0);
`else
    chk("add_count_next", 32'(count), 32'd1);
    chk("add_valid_next", 32'(inst_valid), 32'd1);
    chk("add_fi_next", 32'(inst_fi), 32'd3);
`endif
    tick();
    #3;
    chk("add_count_drained", 32'(count), 32'd0);
    chk("empty_inst_valid", 32'(inst_valid), 32'd0);
    chk("empty_inst_op", 32'(inst_op), 32'd0);
    chk("empty_inst_fi", 32'(inst_fi), 32'd0);

    // 3. Fill under stall, 5th word refused, then drain in order
    tick();
    stall = 1'b1;
    offer(3'd5, 5'd10, 5'd1, 5'd2, 1'b1); tick();
    offer(3'd6, 5'd12, 5'd3, 5'd4, 1'b1); tick();
    offer(3'd0, 5'd11, 5'd5, 5'd6, 1'b1); tick();
    offer(3'd1, 5'd7,  5'd8, 5'd9, 1'b1); tick();
    offer(3'd4, 5'd1,  5'd1, 5'd1, 1'b0);
    #3;
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_head_op", 32'(inst_op), 32'd5);
    chk("full_head_fi", 32'(inst_fi), 32'd10);
    chk("full_head_fu", 32'(inst_fu_type), 32'd2);
    tick();
    #3;
    chk("stall_count_hold", 32'(count), 32'd4);
    chk("stall_head_fi_hold", 32'(inst_fi), 32'd10);
    chk("stall_head_fk_hold", 32'(inst_fk), 32'd2);
    in_valid = 1'b0;
    stall = 1'b0;
    repeat (4) tick();
    #3;
    chk("drain_count", 32'(count), 32'd0);

    // 4. Illegal op, then flush
    tick();
    stall = 1'b1;
    offer(3'd0, 5'd5, 5'd6, 5'd7, 1'b1);
    tick();
    offer(3'd7, 5'd1, 5'd1, 5'd1, 1'b0);
    #3;
    chk("illegal_before_edge", 32'(illegal_seen), 32'd0);
    chk("illegal_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    #3;
    chk("illegal_count", 32'(count), 32'd1);
    chk("illegal_seen_set", 32'(illegal_seen), 32'd1);
    tick();
    flush = 1'b1;
    offer(3'd2, 5'd9, 5'd9, 5'd9, 1'b0);
    #3;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    #3;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_inst_valid", 32'(inst_valid), 32'd0);
    chk("flush_illegal_kept", 32'(illegal_seen), 32'd1);

    // 5. Steady push+pop at count 2 across pointer wrap
    tick();
    offer(3'd1, 5'd20, 5'd21, 5'd22, 1'b1); tick();
    offer(3'd3, 5'd23, 5'd24, 5'd25, 1'b1); tick();
    stall = 1'b0;
    #3;
    chk("stream_count_start", 32'(count), 32'd2);
    for (int i = 0; i < 6; i++) begin
      offer(v_op[i], v_fi[i], 5'd9, 5'd8, 1'b1);
      tick();
      #3;
      chk($sformatf("stream_count_%0d", i), 32'(count), 32'd2);
    end
    in_valid = 1'b0;
    tick();
    tick();
    #3;
    chk("stream_drain_count", 32'(count), 32'd0);

`ifdef IQ_BYPASS_EN
    // 6. Zero-latency bypass into an empty queue
    tick();
    offer(3'd4, 5'd4, 5'd1, 5'd2, 1'b1);
    #3;
    chk("byp_valid", 32'(inst_valid), 32'd1);
    chk("byp_count", 32'(count), 32'd0);
    chk("byp_fi", 32'(inst_fi), 32'd4);
    chk("byp_fu", 32'(inst_fu_type), 32'd0);
    tick();
    in_valid = 1'b0;
    #3;
    chk("byp_count_after", 32'(count), 32'd0);
    chk("byp_valid_after", 32'(inst_valid), 32'd0);
`endif

    // Every expected issue must have been observed within a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
